// File: rtl/mult_wb_queue_pkg.sv
// Shared processor widths and the writeback entry carried from the multiplier to the ROB.
package proc;
  localparam int OPCODE_BITS  = 6;
  localparam int ROB_IDX_BITS = 6;
  localparam int ARCH_BITS    = 32;
  localparam int REG_IDX_BITS = 5;

  localparam logic [OPCODE_BITS-1:0] OPCODE_NOP = '0;

  typedef struct packed {
    logic [OPCODE_BITS-1:0]  opcode;
    logic [ROB_IDX_BITS-1:0] rob_idx;
    logic [ARCH_BITS-1:0]    pc;
    logic [REG_IDX_BITS-1:0] dst_reg;
    logic [ARCH_BITS-1:0]    res_h;
    logic [ARCH_BITS-1:0]    res_l;
  } wb_entry_t;
endpackage

// File: rtl/mult_wb_queue_fifo.sv
// Writeback entry FIFO: wrap-bit pointers, occupancy count, storage left unreset.
module mult_wb_fifo
  import proc::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                wdata,
  output wb_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/mult_wb_queue.sv
// Multiplier writeback queue with issue credit tracking and sticky overflow flag.
// Optional same-cycle bypass of an arrival into an empty queue: define MULT_WB_BYPASS_EN.
module mult_wb_queue
  import proc::*;
#(
  parameter int DEPTH    = 4,
  parameter int MULT_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    multIssue,
  input  logic [OPCODE_BITS-1:0]  opcodeIn,
  input  logic [ROB_IDX_BITS-1:0] robIdxIn,
  input  logic [ARCH_BITS-1:0]    pcIn,
  input  logic [REG_IDX_BITS-1:0] dstRegIn,
  input  logic [ARCH_BITS-1:0]    resHIn,
  input  logic [ARCH_BITS-1:0]    resLIn,
  output logic                    wbValid,
  input  logic                    wbReady,
  output logic [OPCODE_BITS-1:0]  wbOpcode,
  output logic [ROB_IDX_BITS-1:0] wbRobIdx,
  output logic [ARCH_BITS-1:0]    wbPc,
  output logic [REG_IDX_BITS-1:0] wbDstReg,
  output logic [ARCH_BITS-1:0]    wbDataH,
  output logic [ARCH_BITS-1:0]    wbDataL,
  output logic                    canIssue,
  output logic                    ovfErr
);
  localparam int IW = $clog2(MULT_LAT + 1);

  wb_entry_t              in_e, head_e, out_e;
  logic                   arrival, flush, byp;
  logic                   full, empty, fifo_push, fifo_pop;
  logic [$clog2(DEPTH):0] count;
  logic [IW-1:0]          inflight_q, inflight_d;
  logic                   ovf_q, ovf_d;

  assign flush   = rst || clear;
  assign arrival = (opcodeIn != OPCODE_NOP);
  assign in_e    = '{opcode: opcodeIn, rob_idx: robIdxIn, pc: pcIn, dst_reg: dstRegIn,
                     res_h: resHIn, res_l: resLIn};

`ifdef MULT_WB_BYPASS_EN
  assign byp = arrival && empty && !flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry that the ROB takes this cycle never touches storage.
  assign fifo_pop  = !empty && wbReady;
  assign fifo_push = arrival && !flush && !(byp && wbReady) && (!full || fifo_pop);

  mult_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_e),
    .rdata (head_e),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    inflight_d = inflight_q;
    if (multIssue && !arrival && inflight_q != IW'(MULT_LAT))
      inflight_d = inflight_q + 1'b1;
    else if (!multIssue && arrival && inflight_q != '0)
      inflight_d = inflight_q - 1'b1;
    ovf_d = ovf_q | (arrival && full && !fifo_pop && !clear);
  end

  always_ff @(posedge clk) begin
    if (flush) inflight_q <= '0;
    else       inflight_q <= inflight_d;
    if (rst)   ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // Credit uses registered state only; a pop frees its slot from the next cycle on.
  assign canIssue = (int'(count) + int'(inflight_q)) < DEPTH;
  assign ovfErr   = ovf_q;

  assign out_e    = byp ? in_e : head_e;
  assign wbValid  = !empty || byp;
  assign wbOpcode = wbValid ? out_e.opcode : OPCODE_NOP;
  assign wbRobIdx = out_e.rob_idx;
  assign wbPc     = out_e.pc;
  assign wbDstReg = out_e.dst_reg;
  assign wbDataH  = out_e.res_h;
  assign wbDataL  = out_e.res_l;
endmodule

// File: tb/tb_mult_wb_queue.sv
// Directed bench for mult_wb_queue: latency, back-pressure, full/overflow, flush, pointer wrap.
module tb_mult_wb_queue;
  import proc::*;

  localparam logic [OPCODE_BITS-1:0] MUL = 6'h05;

  logic                    clk = 1'b0;
  logic                    rst, clear, multIssue, wbReady;
  logic [OPCODE_BITS-1:0]  opcodeIn;
  logic [ROB_IDX_BITS-1:0] robIdxIn;
  logic [ARCH_BITS-1:0]    pcIn, resHIn, resLIn;
  logic [REG_IDX_BITS-1:0] dstRegIn;
  logic                    wbValid, canIssue, ovfErr;
  logic [OPCODE_BITS-1:0]  wbOpcode;
  logic [ROB_IDX_BITS-1:0] wbRobIdx;
  logic [ARCH_BITS-1:0]    wbPc, wbDataH, wbDataL;
  logic [REG_IDX_BITS-1:0] wbDstReg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_wb_queue #(.DEPTH(4), .MULT_LAT(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .multIssue(multIssue),
    .opcodeIn(opcodeIn), .robIdxIn(robIdxIn), .pcIn(pcIn), .dstRegIn(dstRegIn),
    .resHIn(resHIn), .resLIn(resLIn), .wbValid(wbValid), .wbReady(wbReady),
    .wbOpcode(wbOpcode), .wbRobIdx(wbRobIdx), .wbPc(wbPc), .wbDstReg(wbDstReg),
    .wbDataH(wbDataH), .wbDataL(wbDataL), .canIssue(canIssue), .ovfErr(ovfErr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow a 1ns settle.
  task automatic drive(input logic iss, input logic [OPCODE_BITS-1:0] opc, input int rob,
                       input int resh, input int resl, input logic rdy);
    multIssue = iss;
    opcodeIn  = opc;
    robIdxIn  = ROB_IDX_BITS'(rob);
    pcIn      = 32'h1000 + 32'(rob) * 4;
    dstRegIn  = REG_IDX_BITS'(rob);
    resHIn    = 32'(resh);
    resLIn    = 32'(resl);
    wbReady   = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    step();
    step();
    chk("rst_valid", wbValid, 0);
    chk("rst_can", canIssue, 1);
    chk("rst_ovf", ovfErr, 0);
    chk("rst_opc", wbOpcode, OPCODE_NOP);
    rst = 1'b0;

    // single op: issue at cycle 0, result at cycle 4
    drive(1'b1, OPCODE_NOP, 0, 0, 0, 1'b1);
    chk("t1_can", canIssue, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b1);
      chk("t1_idle_valid", wbValid, 0);
      step();
    end
    drive(1'b0, MUL, 3, 1, 2, 1'b1);
`ifdef MULT_WB_BYPASS_EN
    chk("t1_c4_valid", wbValid, 1);
    chk("t1_c4_rob", wbRobIdx, 3);
    chk("t1_c4_resl", wbDataL, 2);
`else
    chk("t1_c4_valid", wbValid, 0);
`endif
    step();
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b1);
`ifdef MULT_WB_BYPASS_EN
    chk("t1_c5_valid", wbValid, 0);
`else
    chk("t1_c5_valid", wbValid, 1);
    chk("t1_c5_rob", wbRobIdx, 3);
    chk("t1_c5_resh", wbDataH, 1);
    chk("t1_c5_resl", wbDataL, 2);
    chk("t1_c5_opc", wbOpcode, MUL);
    chk("t1_c5_pc", wbPc, 32'h100C);
    chk("t1_c5_dst", wbDstReg, 3);
`endif
    step();
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b1);
    chk("t1_empty_valid", wbValid, 0);
    chk("t1_empty_opc", wbOpcode, OPCODE_NOP);
    step();

    // back-pressure: 4 issues, results 4 cycles later, ROB not ready
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, (i >= 4) ? MUL : OPCODE_NOP, 6 + i, 0, i, 1'b0);
      if (i == 3) chk("bp_can_before", canIssue, 1);
      if (i == 4) chk("bp_can_drop", canIssue, 0);
      if (i == 5) begin
        chk("bp_valid", wbValid, 1);
        chk("bp_rob_first", wbRobIdx, 10);
      end
      step();
    end
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    chk("bp_full_can", canIssue, 0);
    chk("bp_hold_valid", wbValid, 1);
    chk("bp_hold_rob", wbRobIdx, 10);
    chk("bp_hold_resl", wbDataL, 4);
    step();

    // full with pop and push in the same cycle
    drive(1'b0, MUL, 14, 0, 14, 1'b1);
    chk("fpp_head", wbRobIdx, 10);
    step();
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    chk("fpp_head_adv", wbRobIdx, 11);
    chk("fpp_still_full", canIssue, 0);
    chk("fpp_no_ovf", ovfErr, 0);
    step();

    // forced overflow: arrival while full and not ready
    drive(1'b0, MUL, 20, 0, 20, 1'b0);
    step();
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    chk("ovf_set", ovfErr, 1);
    chk("ovf_head", wbRobIdx, 11);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b1);
      chk("drain_valid", wbValid, 1);
      chk("drain_rob", wbRobIdx, 11 + k);
      step();
    end
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    chk("drain_empty", wbValid, 0);
    chk("drain_can", canIssue, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    chk("ovf_after_clear", ovfErr, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    chk("ovf_after_rst", ovfErr, 0);
    step();

    // clear with 2 queued and 2 in flight
    drive(1'b1, OPCODE_NOP, 0, 0, 0, 1'b0);
    step();
    drive(1'b1, OPCODE_NOP, 0, 0, 0, 1'b0);
    step();
    drive(1'b1, MUL, 30, 0, 30, 1'b0);
    step();
    drive(1'b1, MUL, 31, 0, 31, 1'b0);
    step();
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    chk("clr_pre_can", canIssue, 0);
    chk("clr_pre_rob", wbRobIdx, 30);
    clear = 1'b1;
    drive(1'b1, MUL, 32, 0, 32, 1'b0);
    step();
    clear = 1'b0;
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b1);
    chk("clr_valid", wbValid, 0);
    chk("clr_can", canIssue, 1);
    chk("clr_opc", wbOpcode, OPCODE_NOP);
    step();
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b1);
    chk("clr_nop_valid", wbValid, 0);
    step();
    // exactly 4 issues must exhaust credit, so nothing stale survived the clear
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OPCODE_NOP, 0, 0, 0, 1'b0);
      chk("clr_credit", canIssue, 1);
      step();
    end
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b0);
    chk("clr_credit_out", canIssue, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // pointer wrap: 10 back-to-back results, ROB always ready
    for (int k = 0; k <= 10; k++) begin
      drive(1'b0, (k < 10) ? MUL : OPCODE_NOP, k, 0, k * 7, 1'b1);
`ifdef MULT_WB_BYPASS_EN
      chk("wrap_valid", wbValid, (k < 10));
      if (k < 10) begin
        chk("wrap_rob", wbRobIdx, k);
        chk("wrap_resl", wbDataL, k * 7);
      end
`else
      chk("wrap_valid", wbValid, (k >= 1));
      if (k >= 1) begin
        chk("wrap_rob", wbRobIdx, k - 1);
        chk("wrap_resl", wbDataL, (k - 1) * 7);
      end
`endif
      step();
    end
    drive(1'b0, OPCODE_NOP, 0, 0, 0, 1'b1);
    chk("wrap_done", wbValid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
